mem_access_ctrl: RTL
====================

# mem_access_ctrl

Memory-stage data-bus sequencer. Accepts one load/store per handshake from the pipeline, forms byte-lane data and strobe, runs the two-phase data-bus transaction (address accepted, then data returned), and hands back load data extracted and sign/zero-extended to 64 bits. It sits between the memory-stage pipeline register and the core's data-bus port. It is the only driver of that port.

## Interface
- No parameters; widths fixed (64-bit address/data, 8-byte strobe).
- clk  in  1  core clock
- reset  in  1  synchronous, active-low; sampled on rising clk; 0 = reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  controller can accept; high only in IDLE
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- req_msize  in  2  0=1B, 1=2B, 2=4B, 3=8B
- req_is_store  in  1  1=store, 0=load
- req_sign_ext  in  1  loads only: 1=sign-extend, 0=zero-extend
- flush  in  1  kill the in-flight access's response
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  64  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access (valid with resp_valid)
- dreq_valid  out  1  bus request
- dreq_addr  out  64  request address, exactly req_addr
- dreq_size  out  3  {1'b0, msize}
- dreq_strobe  out  8  byte enables; 0 for loads
- dreq_data  out  64  lane-placed store data
- dresp_addr_ok  in  1  bus accepted address
- dresp_data_ok  in  1  bus finished; dresp_data valid
- dresp_data  in  64  raw 64-bit read word

## Operation
- States: IDLE, ADDR, DATA, RESP.
- IDLE: req_ready=1. On req_valid, latch all req_* fields and compute the alignment check.
  - Aligned: go to ADDR.
  - Misaligned: go to RESP with err set. Misaligned means addr[0]!=0 for 2B, addr[1:0]!=0 for 4B, addr[2:0]!=0 for 8B.
- ADDR: dreq_valid=1. All dreq_* are driven from latched registers and held stable.
  - addr_ok&data_ok in the same cycle: go to RESP.
  - addr_ok only: go to DATA.
  - Otherwise: stay in ADDR.
- DATA: dreq_valid=0. On data_ok, go to RESP. Capture dresp_data in the data_ok cycle.
- RESP: resp_valid=1 unless the access is killed. Always return to IDLE next cycle.
- Lane placement: k = addr[2:0].
  - Store data is shifted left by 8*k.
  - Strobe is ((1<<bytes)-1)<<k: 1B gives 8'h01..8'h80; 2B gives 03/0c/30/c0; 4B gives 0f/f0; 8B gives ff.
- Load extraction: dresp_data>>(8*k), truncated to size, then sign- or zero-extended per the latched sign_ext.
- Flush:
  - In ADDR or DATA: set the kill flag. The bus transaction still runs to data_ok, because a bus request is never withdrawn. RESP then suppresses resp_valid.
  - In RESP: suppresses that cycle's resp_valid.
  - In IDLE: ignored. flush and req_valid in the same IDLE cycle means the request is not accepted; req_ready is forced 0 while flush=1.
- Reset: state=IDLE, kill=0; all outputs 0 except req_ready=1. Reset mid-transaction abandons it; the bus side must tolerate this.

## Timing
- Request accepted in cycle 0; dreq_valid first high in cycle 1.
- Zero-wait bus (addr_ok&data_ok in cycle 1): resp_valid in cycle 2, req_ready in cycle 3.
- Misaligned: resp_valid/resp_err in cycle 1; no dreq_valid at any point.
- Every output is registered or decoded from state/latched registers only. There is no combinational path from dresp_* or req_* to outputs, except:
  - resp_rdata comes from a register captured at data_ok;
  - req_ready depends on the flush input.
- Throughput: one access per 3 cycles minimum.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: misalignment check active as described; resp_err can be 1.
- Not defined:
  - No check is made. resp_err is tied to 0.
  - The access is issued with dreq_addr aligned down to the access size.
  - k is taken from the aligned address, so strobe and data are placed in the naturally aligned slot.

## Test plan
- Store byte: addr=0x8000_0005, msize=0, wdata=0xAB, zero-wait bus -> dreq_strobe=8'h20, dreq_data=0x0000_AB00_0000_0000, dreq_size=0; resp_valid in cycle 2, rdata=0.
- Signed halfword load: addr=0x...06, sign_ext=1, dresp_data=0x8001_0000_0000_0000, data_ok 3 cycles after addr_ok -> resp_rdata=0xFFFF_FFFF_FFFF_8001, strobe=0.
- Unsigned word load: addr=0x...04, sign_ext=0, dresp_data=0xF000_0000_1234_5678 -> resp_rdata=0x0000_0000_F000_0000.
- Misaligned 8B store at 0x...03 with trap enabled -> dreq_valid never asserted, resp_valid=resp_err=1 in cycle 1. With the macro off -> dreq_addr=0x...00, strobe=8'hff.
- addr_ok withheld 4 cycles: dreq_* stay stable and dreq_valid stays high throughout. flush pulsed in DATA -> transaction completes, resp_valid stays 0, req_ready=1 the cycle after RESP.
- reset=0 asserted while in DATA -> next cycle IDLE, dreq_valid=0, resp_valid=0, req_ready=1.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage data-bus sequencer. Accepts one load/store per handshake,
// places store data and byte strobes on the proper lanes, runs the two-phase
// data-bus transaction (address accepted, then data returned), and returns
// load data extracted from the bus word and sign/zero-extended to 64 bits.
// This block is the only driver of the core's data-bus request port.
//
// Configuration macro:
//   MEM_MISALIGN_TRAP_EN  defined   : misaligned accesses are not issued to the
//                                     bus; they complete at once with resp_err=1.
//                         undefined : no alignment check; the address is
//                                     aligned down to the access size and
//                                     resp_err is tied to 0.
//
// Ports:
//   clk, reset         core clock; synchronous active-low reset (0 = reset)
//   req_valid/ready    pipeline handshake (ready only in IDLE and not flushing)
//   req_addr/wdata     byte address, right-aligned store data
//   req_msize          0=1B 1=2B 2=4B 3=8B
//   req_is_store       1=store 0=load
//   req_sign_ext       loads: 1=sign-extend 0=zero-extend
//   flush              kill the in-flight access's response
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores and errors)
//   resp_err           misaligned access, qualified by resp_valid
//   dreq_*             bus request: valid, addr, size, strobe, lane-placed data
//   dresp_addr_ok      bus accepted the address
//   dresp_data_ok      bus finished; dresp_data valid this cycle
//   dresp_data         raw 64-bit read word
// -----------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_msize,
  input  logic        req_is_store,
  input  logic        req_sign_ext,
  input  logic        flush,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [2:0]  dreq_size,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_addr_ok,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state_q, state_d;

  // Latched request, already lane-placed so the bus side sees stable values.
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [7:0]  strobe_q;
  logic [1:0]  msize_q;
  logic        is_store_q;
  logic        sign_ext_q;
  logic        kill_q;
  logic [63:0] rdata_q;

  // ---------------------------------------------------------------------------
  // Request decode (only meaningful while IDLE)
  // ---------------------------------------------------------------------------
  logic        accept;
  logic        accept_err;
  logic [2:0]  lo_mask;     // address bits that must be zero for this size
  logic [7:0]  byte_mask;   // right-aligned strobe for this size
  logic [63:0] issue_addr;
  logic [2:0]  issue_k;

  assign accept = (state_q == IDLE) && req_valid && !flush;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    lo_mask   = 3'b000;
    byte_mask = 8'h01;
    unique case (req_msize)
      2'd0: begin lo_mask = 3'b000; byte_mask = 8'h01; end
      2'd1: begin lo_mask = 3'b001; byte_mask = 8'h03; end
      2'd2: begin lo_mask = 3'b011; byte_mask = 8'h0f; end
      2'd3: begin lo_mask = 3'b111; byte_mask = 8'hff; end
    endcase
  end

`ifdef MEM_MISALIGN_TRAP_EN
  assign issue_addr = req_addr;
  assign accept_err = |(req_addr[2:0] & lo_mask);
`else
  // Misaligned requests are silently snapped to their natural slot.
  assign issue_addr = {req_addr[63:3], req_addr[2:0] & ~lo_mask};
  assign accept_err = 1'b0;
`endif

  assign issue_k = issue_addr[2:0];

  // ---------------------------------------------------------------------------
  // Load extraction from the raw bus word
  // ---------------------------------------------------------------------------
  logic [63:0] rd_shifted;
  logic [63:0] rd_ext;

  assign rd_shifted = dresp_data >> {addr_q[2:0], 3'b000};

  always_comb begin
    rd_ext = 64'd0;
    unique case (msize_q)
      2'd0: rd_ext = {{56{sign_ext_q & rd_shifted[7]}},  rd_shifted[7:0]};
      2'd1: rd_ext = {{48{sign_ext_q & rd_shifted[15]}}, rd_shifted[15:0]};
      2'd2: rd_ext = {{32{sign_ext_q & rd_shifted[31]}}, rd_shifted[31:0]};
      2'd3: rd_ext = rd_shifted;
    endcase
  end

  logic capture;
  assign capture = ((state_q == ADDR) && dresp_addr_ok && dresp_data_ok) ||
                   ((state_q == DATA) && dresp_data_ok);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = accept_err ? RESP : ADDR;
      ADDR: begin
        if (dresp_addr_ok && dresp_data_ok) state_d = RESP;
        else if (dresp_addr_ok)             state_d = DATA;
      end
      DATA: if (dresp_data_ok) state_d = RESP;
      RESP: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      strobe_q   <= '0;
      msize_q    <= '0;
      is_store_q <= 1'b0;
      sign_ext_q <= 1'b0;
      kill_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_q     <= issue_addr;
        wdata_q    <= req_wdata << {issue_k, 3'b000};
        strobe_q   <= req_is_store ? (byte_mask << issue_k) : 8'h00;
        msize_q    <= req_msize;
        is_store_q <= req_is_store;
        sign_ext_q <= req_sign_ext;
        kill_q     <= 1'b0;
        rdata_q    <= '0;   // stays 0 for stores and trapped accesses
      end else begin
        // A flushed bus access still completes; only its response is dropped.
        if (flush && (state_q == ADDR || state_q == DATA)) kill_q <= 1'b1;
        if (capture) rdata_q <= is_store_q ? 64'd0 : rd_ext;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (!reset)      err_q <= 1'b0;
    else if (accept) err_q <= accept_err;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state and latched registers only
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready   = (state_q == IDLE) && !flush;
    resp_valid  = (state_q == RESP) && !kill_q && !flush;
    dreq_valid  = (state_q == ADDR);
    resp_rdata  = resp_valid ? rdata_q : 64'd0;
    dreq_addr   = dreq_valid ? addr_q : 64'd0;
    dreq_size   = dreq_valid ? {1'b0, msize_q} : 3'd0;
    dreq_strobe = dreq_valid ? strobe_q : 8'h00;
    dreq_data   = dreq_valid ? wdata_q : 64'd0;
`ifdef MEM_MISALIGN_TRAP_EN
    resp_err    = resp_valid && err_q;
`else
    resp_err    = 1'b0;
`endif
  end

endmodule
